// File: rtl/hemaia_clk_rst_sequencer_pkg.sv
// Shared constants and types for the HeMAiA clock/reset power-up sequencer.
// Register offsets are relative to the controller's register file base.
package hemaia_clk_rst_sequencer_pkg;

  localparam logic [47:0] DIV_BASE = 48'h00;
  localparam logic [47:0] VALID    = 48'h20;
  localparam logic [47:0] RESET    = 48'h24;

  typedef enum logic [2:0] {
    IDLE,
    RST_ALL,
    WR_DIV,
    WR_VALID,
    SETTLE,
    RELEASE,
    DONE
  } state_e;

  // Mask with the n least significant bits set (n saturates at 32).
  function automatic logic [31:0] low_ones(input int unsigned n);
    logic [31:0] m;
    for (int unsigned b = 0; b < 32; b++) begin
      m[b] = (b < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/hemaia_clk_rst_sequencer_if.sv
// Write-only register bus between the sequencer and the clock/reset controller.
interface hemaia_clk_rst_sequencer_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32
);
  logic                   reg_valid;
  logic [AddrWidth-1:0]   reg_addr;
  logic [DataWidth-1:0]   reg_wdata;
  logic [DataWidth/8-1:0] reg_wstrb;
  logic                   reg_write;
  logic                   reg_ready;
  logic                   reg_error;

  modport master (
    output reg_valid, reg_addr, reg_wdata, reg_wstrb, reg_write,
    input  reg_ready, reg_error
  );

  modport slave (
    input  reg_valid, reg_addr, reg_wdata, reg_wstrb, reg_write,
    output reg_ready, reg_error
  );
endinterface

// File: rtl/hemaia_reg_write_master.sv
// Single-outstanding register write port: holds a request until accepted and
// reports the handshake and any target error back to the issuing FSM.
module hemaia_reg_write_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req,
  input  logic [47:0] addr,
  input  logic [31:0] data,
  output logic        ack,
  output logic        err,
  hemaia_clk_rst_sequencer_if.master bus
);

  logic        valid_q;
  logic [47:0] addr_q;
  logic [31:0] data_q;

  // A new request may be loaded in the accept cycle, giving back-to-back writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (req) begin
      valid_q <= 1'b1;
      addr_q  <= addr;
      data_q  <= data;
    end else if (ack) begin
      valid_q <= 1'b0;
    end
  end

  assign ack = valid_q & bus.reg_ready;
  assign err = ack & bus.reg_error;

  assign bus.reg_valid = valid_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = data_q;
  assign bus.reg_wstrb = '1;
  assign bus.reg_write = 1'b1;

endmodule

// File: rtl/hemaia_clk_rst_sequencer.sv
// Power-up sequencer: resets all domains, programs divisors, commits them and
// releases domain resets one by one with a settle delay before each release.
module hemaia_clk_rst_sequencer
  import hemaia_clk_rst_sequencer_pkg::*;
#(
  parameter int unsigned NumClocks        = 4,
  parameter int unsigned MaxDivisionWidth = 8,
  parameter logic [47:0] BaseAddr         = 48'h0,
  parameter int unsigned SettleCycles     = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic [NumClocks*MaxDivisionWidth-1:0]  divisor_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   error_o,
  hemaia_clk_rst_sequencer_if.master             reg_bus
);

  localparam int unsigned NumWords    = (NumClocks + 3) / 4;
  localparam int unsigned CntWidth    = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam int unsigned DivVecWidth = NumClocks * MaxDivisionWidth;

  state_e                 state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [4:0]             i_q, i_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [DivVecWidth-1:0] div_q, div_d;
  logic                   err_q, err_d;
  logic                   busy_q, done_q;

  logic        req;
  logic [47:0] req_addr;
  logic [31:0] req_data;
  logic        ack;
  logic        bus_err;

  // DIV_k word: byte lane j carries domain 4k+j, zero-extended; absent domains read 0.
  function automatic logic [31:0] div_word(input logic [DivVecWidth-1:0] div,
                                           input logic [2:0] k);
    logic [31:0] w;
    int unsigned d;
    w = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      d = 4 * 32'(k) + j;
      if (d < NumClocks) begin
        w[8*j +: MaxDivisionWidth] = div[d*MaxDivisionWidth +: MaxDivisionWidth];
      end
    end
    return w;
  endfunction

  function automatic logic [47:0] div_addr(input logic [2:0] k);
    return BaseAddr + DIV_BASE + {43'd0, k, 2'b00};
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    i_d      = i_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    err_d    = err_q;
    req      = 1'b0;
    req_addr = BaseAddr + RESET;
    req_data = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          div_d   = divisor_i;
          err_d   = 1'b0;
          k_d     = '0;
          i_d     = '0;
          req     = 1'b1;
          state_d = RST_ALL;
        end
      end
      RST_ALL: begin
        if (ack) begin
          req      = 1'b1;
          req_addr = div_addr(3'd0);
          req_data = div_word(div_q, 3'd0);
          state_d  = WR_DIV;
        end
      end
      WR_DIV: begin
        if (ack) begin
          req = 1'b1;
          if (k_q == 3'(NumWords - 1)) begin
            req_addr = BaseAddr + VALID;
            req_data = low_ones(NumClocks);
            state_d  = WR_VALID;
          end else begin
            k_d      = k_q + 3'd1;
            req_addr = div_addr(k_d);
            req_data = div_word(div_q, k_d);
          end
        end
      end
      WR_VALID: begin
        if (ack) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CntWidth'(SettleCycles - 1)) begin
          req      = 1'b1;
          req_data = low_ones(32'(i_q) + 32'd1);
          state_d  = RELEASE;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RELEASE: begin
        if (ack) begin
          if (i_q == 5'(NumClocks - 1)) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + 5'd1;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A rejected write overrides whatever the state above planned to issue next.
    if (bus_err) begin
      req     = 1'b0;
      err_d   = 1'b1;
      state_d = DONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE) && (state_d != DONE);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = err_q;

  hemaia_reg_write_master u_write_master (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req),
    .addr   (req_addr),
    .data   (req_data),
    .ack    (ack),
    .err    (bus_err),
    .bus    (reg_bus)
  );

endmodule

// File: doc/hemaia_clk_rst_sequencer.md
# hemaia_clk_rst_sequencer

Autonomous power-up and reconfiguration sequencer for the HeMAiA clock/reset controller. On a start pulse it masters the controller's 32-bit register bus: it asserts all local resets, programs every clock divisor, commits them via the self-clearing valid register, then releases domain resets one at a time in ascending index order, with a fixed settle delay before each release. It sits in the control-clock domain in front of the controller's register port, sharing its clock and reset, and replaces boot-ROM software sequencing.

## Interface
- NumClocks, 4, number of clock domains sequenced (1..32)
- MaxDivisionWidth, 8, width of each divisor (1..8)
- BaseAddr, 48'h0, byte base address of the clock/reset controller register file
- SettleCycles, 16, idle cycles before each reset-release write (≥1)
- clk_i  in  1  control clock
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle start request; ignored while busy_o=1
- divisor_i  in  NumClocks×MaxDivisionWidth  per-domain divisor, sampled on accepted start
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at end of sequence (normal or aborted)
- error_o  out  1  sticky: last sequence aborted on bus error; cleared on next accepted start
- reg_valid_o  out  1  register write request
- reg_addr_o  out  48  byte address
- reg_wdata_o  out  32  write data
- reg_wstrb_o  out  4  always 4'hF
- reg_write_o  out  1  always 1
- reg_ready_i  in  1  target accepts request
- reg_error_i  in  1  target error, valid with reg_ready_i

## Operation
- Register map (offsets from BaseAddr): DIV_k at 0x00+4k (k=0..7, domains 4k..4k+3, domain 4k+j in bits [8j+7:8j], zero-extended); VALID at 0x20; RESET at 0x24 (bit i = 1 releases domain i).
- FSM states: IDLE, RST_ALL, WR_DIV, WR_VALID, SETTLE, RELEASE, DONE.
- IDLE: start_i=1 latches divisor_i, clears error_o, loads word counter k=0 and domain index i=0, goes to RST_ALL.
- RST_ALL: write RESET=0.
- WR_DIV: write DIV_k for k = 0..ceil(NumClocks/4)-1; lanes for indices ≥ NumClocks are 0.
- WR_VALID: write VALID with bits [NumClocks-1:0]=1, others 0.
- SETTLE: count SettleCycles cycles, then go to RELEASE.
- RELEASE: write RESET with bits [i:0]=1; i==NumClocks-1 → DONE, else i++ and back to SETTLE.
- DONE: done_o=1 for one cycle, return to IDLE.
- Total writes = 2 + ceil(NumClocks/4) + NumClocks.
- Bus error (reg_valid_o & reg_ready_i & reg_error_i): set error_o, go directly to DONE; no further writes.
- Divisor values are forwarded unmodified (0 is not rewritten).

## Timing
- Reset values: busy_o=0, done_o=0, error_o=0, reg_valid_o=0, reg_addr_o=0, reg_wdata_o=0; FSM in IDLE; all outputs registered.
- Start accepted at edge t → busy_o=1 and first reg_valid_o=1 at t+1.
- Handshake: reg_valid_o stays high with addr/wdata stable until the cycle reg_valid_o & reg_ready_i; the next request is issued no earlier than the following cycle (zero bubble between back-to-back writes; reg_ready_i may be combinationally high).
- reg_valid_o is never dropped without a handshake.
- SETTLE: reg_valid_o=0 for exactly SettleCycles cycles between release writes and between WR_VALID and the first release.
- done_o pulses the cycle after the final handshake; busy_o falls in the same cycle as the done_o pulse.
- start_i while busy_o=1, including the done_o cycle: dropped, not queued.
- Async reset mid-sequence: immediate return to reset values; an outstanding request is abandoned.

## Structure
- Package hemaia_clk_rst_sequencer_pkg: register offset constants (DIV_BASE, VALID, RESET), state enum.
- Sub-module hemaia_reg_write_master: single-outstanding valid/ready write port with hold-until-accept and error capture; the FSM only issues (addr, data) and consumes ack/err.

## Test plan
- NumClocks=4, divisors {1,2,3,4}, ready always 1 → writes RESET=0, DIV_0=0x04030201, VALID=0xF, RESET=0x1,0x3,0x7,0xF; 16 idle cycles before each RESET release write; done_o once.
- NumClocks=6 → DIV_0 and DIV_1 written, DIV_1 upper lanes 0; VALID=0x3F; six release writes ending 0x3F.
- Random reg_ready_i backpressure (0–5 cycles) → addr/wdata stable while stalled, same write sequence, no dropped or duplicated write.
- reg_error_i on the VALID write → no further writes, done_o pulse, error_o=1; next start clears error_o and completes cleanly.
- start_i during SETTLE, and during the done_o cycle → ignored, sequence unchanged.
- rst_ni asserted during WR_DIV stall → all outputs 0 next cycle; a new start after reset replays the full sequence from RESET=0.
